// File: rtl/udp_pkt_buffer_if.sv
// Encoder-side write bus and consumer-side read bus of the
// UDP packet buffer, plus its sticky status flags.
interface udp_pkt_buffer_if;
  logic [31:0] pkg_data;
  logic        wr_en;
  logic        fin;
  logic [15:0] checksum_in;
  logic [15:0] len_in;
  logic        rd_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        done;
  logic        overflow;
  logic        len_err;

  modport master (
    output pkg_data, wr_en, fin,
    output checksum_in, len_in, rd_ready,
    input  out_data, out_valid, out_last,
    input  done, overflow, len_err
  );

  modport slave (
    input  pkg_data, wr_en, fin,
    input  checksum_in, len_in, rd_ready,
    output out_data, out_valid, out_last,
    output done, overflow, len_err
  );
endinterface

// File: rtl/udp_pkt_buffer.sv
// Buffers one UDP packet, patches the checksum into word 1,
// then streams it out with a valid/ready handshake.
module udp_pkt_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  udp_pkt_buffer_if.slave  io_bus
);

  typedef logic [ADDR_W:0] ptr_t;
  typedef enum logic [1:0] {
    COLLECT,
    PATCH,
    SEND,
    DONE
  } state_t;

  localparam ptr_t FULL = ptr_t'(DEPTH);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mem [DEPTH];
  ptr_t        r_wr_ptr;
  ptr_t        r_rd_ptr;
  ptr_t        r_wc;
  logic [15:0] r_csum;
  logic [15:0] r_len;
  logic        r_ovf;
  logic        r_lerr;

  logic        w_collect;
  logic        w_wr_ok;
  logic        w_drop;
  logic        w_short;
  logic        w_last;
  logic        w_len_bad;
  ptr_t        w_cnt;
  logic [16:0] w_exp;

  assign w_collect = r_state == COLLECT;
  assign w_wr_ok   = w_collect && io_bus.wr_en
                     && (r_wr_ptr < FULL);
  assign w_drop    = w_collect && io_bus.wr_en
                     && (r_wr_ptr >= FULL);
  assign w_cnt     = r_wr_ptr + ptr_t'(w_wr_ok);
  assign w_short   = w_cnt < ptr_t'(2);
  assign w_last    = r_rd_ptr == (r_wc - ptr_t'(1));
  // Expected word count rounds the byte length up
  assign w_exp     = ({1'b0, r_len} + 17'd3) >> 2;
  assign w_len_bad = w_exp != 17'(r_wc);

  assign io_bus.out_valid = r_state == SEND;
  assign io_bus.out_last  = (r_state == SEND) && w_last;
  assign io_bus.done      = r_state == DONE;
  assign io_bus.out_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign io_bus.overflow  = r_ovf;
  assign io_bus.len_err   = r_lerr;

  always_ff @(posedge clk) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      COLLECT: begin
        if (io_bus.fin)
          w_next = w_short ? DONE : PATCH;
      end
      PATCH: w_next = SEND;
      SEND: begin
        if (io_bus.rd_ready && w_last)
          w_next = DONE;
      end
      DONE: begin
        if (!io_bus.fin)
          w_next = COLLECT;
      end
      default: w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_wc     <= '0;
      r_csum   <= '0;
      r_len    <= '0;
      r_ovf    <= 1'b0;
      r_lerr   <= 1'b0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_wr_ok) r_wr_ptr <= w_cnt;
          if (w_drop)  r_ovf <= 1'b1;
          if (io_bus.fin) begin
            r_csum <= io_bus.checksum_in;
            r_len  <= io_bus.len_in;
            r_wc   <= w_cnt;
            if (w_short) r_lerr <= 1'b1;
          end
        end
        PATCH: begin
          r_rd_ptr <= '0;
          if (w_len_bad) r_lerr <= 1'b1;
        end
        SEND: begin
          if (io_bus.rd_ready && !w_last)
            r_rd_ptr <= r_rd_ptr + ptr_t'(1);
        end
        DONE: begin
          if (!io_bus.fin) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_wc     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Packet storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= io_bus.pkg_data;
    else if (r_state == PATCH)
      r_mem[1][15:0] <= r_csum;
  end

endmodule

// File: tb/tb_udp_pkt_buffer.sv
// Randomized bench for udp_pkt_buffer against a packet-level
// model of what the consumer should receive.
module tb_udp_pkt_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  udp_pkt_buffer_if u_bus();

  udp_pkt_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (u_bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] pend [$];
  bit          m_ovf = 1'b0;
  bit          m_lerr = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    u_bus.pkg_data    = '0;
    u_bus.wr_en       = 1'b0;
    u_bus.fin         = 1'b0;
    u_bus.checksum_in = '0;
    u_bus.len_in      = '0;
    u_bus.rd_ready    = 1'b0;
  endtask

  task automatic junk();
    u_bus.wr_en    = 1'($urandom_range(0, 1));
    u_bus.pkg_data = $urandom;
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, {27'd0, u_bus.out_valid, u_bus.out_last,
              u_bus.done, u_bus.overflow, u_bus.len_err}, 0);
  endtask

  // mode 0: always ready, 1: 1,0,0,1,1 then ready, 2: random
  task automatic run_pkt(input logic [15:0] len,
                         input logic [15:0] csum,
                         input int mode,
                         input bit fin_w,
                         input int abort_at,
                         input int hold);
    logic [31:0] exp [$];
    logic [31:0] t;
    bit [0:4]    pat = 5'b10011;
    int n, wc, i, idx, cyc, xfers;
    bit r, aborted;
    n = pend.size();
    for (int k = 0; k < n && k < DEPTH; k++)
      exp.push_back(pend[k]);
    wc = exp.size();
    if (n > DEPTH) m_ovf = 1'b1;
    if (wc < 2) m_lerr = 1'b1;
    else begin
      t = exp[1];
      t[15:0] = csum;
      exp[1] = t;
      if (wc != (int'(len) + 3) / 4) m_lerr = 1'b1;
    end
    u_bus.checksum_in = csum;
    u_bus.len_in = len;
    i = 0;
    while (i < n) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        u_bus.wr_en = 1'b1;
        u_bus.pkg_data = pend[i];
        u_bus.fin = fin_w && (i == n - 1);
        i++;
      end else begin
        u_bus.wr_en = 1'b0;
        u_bus.pkg_data = $urandom;
      end
    end
    if (!fin_w) begin
      @(negedge clk);
      u_bus.wr_en = 1'b0;
      u_bus.fin = 1'b1;
    end
    @(negedge clk);
    junk();
    if (wc < 2) begin
      chk("direct_done", {30'd0, u_bus.out_valid, u_bus.done}, 1);
    end else begin
      chk("patch_idle", {30'd0, u_bus.out_valid, u_bus.done}, 0);
      idx = 0;
      cyc = 0;
      xfers = 0;
      aborted = 1'b0;
      @(negedge clk);
      while (idx < wc && cyc < 100 && !aborted) begin
        chk("valid", 32'(u_bus.out_valid), 1);
        chk("data", u_bus.out_data, exp[idx]);
        chk("last", 32'(u_bus.out_last), 32'(idx == wc - 1));
        case (mode)
          0:       r = 1'b1;
          1:       r = (cyc < 5) ? pat[cyc] : 1'b1;
          default: r = $urandom_range(0, 2) != 0;
        endcase
        u_bus.rd_ready = r;
        junk();
        if (r) begin
          idx++;
          xfers++;
          if (idx == abort_at) aborted = 1'b1;
        end
        cyc++;
        @(negedge clk);
      end
      if (aborted) begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        outs_zero("rst_mid_send");
        reset = 1'b0;
        m_ovf = 1'b0;
        m_lerr = 1'b0;
        pend.delete();
        return;
      end
      chk("xfers", xfers, wc);
      u_bus.rd_ready = 1'b0;
      chk("end_done", {30'd0, u_bus.out_valid, u_bus.done}, 1);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      junk();
      chk("hold", {30'd0, u_bus.out_valid, u_bus.done}, 1);
    end
    u_bus.fin = 1'b0;
    u_bus.wr_en = 1'b0;
    u_bus.rd_ready = 1'b0;
    @(negedge clk);
    chk("rearm", 32'(u_bus.done), 0);
    chk("ovf", 32'(u_bus.overflow), 32'(m_ovf));
    chk("lerr", 32'(u_bus.len_err), 32'(m_lerr));
    pend.delete();
  endtask

  task automatic basic_words();
    pend = {32'h12340050, 32'h000C0000, 32'hDEADBEEF};
  endtask

  task automatic rand_words(input int n);
    for (int k = 0; k < n; k++) pend.push_back($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, wcx, ab;
    logic [15:0] len;
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    outs_zero("reset_state");
    reset = 1'b0;

    basic_words();
    run_pkt(16'd12, 16'hABCD, 0, 1'b0, -1, 1);
    basic_words();
    run_pkt(16'd12, 16'hABCD, 1, 1'b0, -1, 1);
    rand_words(1);
    run_pkt(16'd4, 16'h1111, 0, 1'b0, -1, 2);
    rand_words(6);
    run_pkt(16'd24, 16'h2222, 0, 1'b0, -1, 10);
    basic_words();
    run_pkt(16'd12, 16'hABCD, 0, 1'b0, -1, 3);
    rand_words(4);
    run_pkt(16'd16, 16'h3333, 0, 1'b0, 2, 0);
    basic_words();
    run_pkt(16'd12, 16'hABCD, 0, 1'b1, -1, 1);

    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 6);
      wcx = (n < DEPTH) ? n : DEPTH;
      if ($urandom_range(0, 3) == 0)
        len = 16'($urandom_range(0, 40));
      else
        len = 16'(4 * wcx - $urandom_range(0, 3));
      ab = -1;
      if (wcx >= 3 && $urandom_range(0, 7) == 0)
        ab = $urandom_range(1, wcx - 1);
      rand_words(n);
      run_pkt(len, 16'($urandom), 2,
              1'($urandom_range(0, 1)), ab,
              $urandom_range(0, 10));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
